// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared branch type codes and branch FSM state encoding
package branch_ctrl_pkg;
   localparam logic [5:0] BEQ   = 6'h04;
   localparam logic [5:0] BNE   = 6'h05;
   localparam logic [5:0] BGTZL = 6'h17;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_NULL = 2'd2} state_t;
endpackage

// File: rtl/branch_ctrl_br_cond.sv
// br_cond: decodes d_type and evaluates op_a/op_b into taken, is_branch, need_b
module br_cond
   import branch_ctrl_pkg::*;
(
   input  logic [5:0]  d_type,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        taken,
   output logic        is_branch,
   output logic        need_b
);
   always_comb begin
      is_branch = d_type == BEQ || d_type == BNE || d_type == BGTZL;
      need_b    = d_type == BEQ || d_type == BNE;
      taken     = d_type == BEQ   ? op_a == op_b :
                  d_type == BNE   ? op_a != op_b :
                  d_type == BGTZL ? $signed(op_a) > 32'sd0 : 1'b0;
   end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: D-stage branch resolve FSM (operands/type/target in; stall_d, pc_sel, br_target, null_f, statistics counters out)
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             d_valid,
   input  logic [5:0]       d_type,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   input  logic             op_a_rdy,
   input  logic             op_b_rdy,
   input  logic [31:0]      d_target,
   input  logic             pipe_flush,
   output logic             stall_d,
   output logic             pc_sel,
   output logic [31:0]      br_target,
   output logic             null_f,
   output logic [CNT_W-1:0] cnt_total,
   output logic [CNT_W-1:0] cnt_taken,
   output logic [CNT_W-1:0] cnt_null
);
   state_t state;
   logic taken, is_branch, need_b, live, active, resolve, to_null;
   br_cond u_cond (
      .d_type    (d_type),
      .op_a      (op_a),
      .op_b      (op_b),
      .taken     (taken),
      .is_branch (is_branch),
      .need_b    (need_b)
   );
   always_comb begin
      live      = !reset && !pipe_flush;
      active    = live && state != S_NULL && d_valid && is_branch;
      resolve   = active && op_a_rdy && (op_b_rdy || !need_b);
      to_null   = resolve && !need_b && !taken;
      stall_d   = active && !resolve;
      pc_sel    = resolve && taken;
      br_target = pc_sel ? d_target : '0;
      null_f    = live && state == S_NULL;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt_total <= '0;
         cnt_taken <= '0;
         cnt_null  <= '0;
      end else begin
         state     <= pipe_flush ? S_IDLE : to_null ? S_NULL : stall_d ? S_WAIT : S_IDLE;
         cnt_total <= cnt_total + CNT_W'(resolve);
         cnt_taken <= cnt_taken + CNT_W'(pc_sel);
         cnt_null  <= cnt_null + CNT_W'(to_null);
      end
   end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_branch_ctrl;
   import branch_ctrl_pkg::*;
   typedef struct {
      logic        v;
      logic [5:0]  t;
      logic [31:0] a;
      logic [31:0] b;
      logic        ar;
      logic        br;
      logic [31:0] tgt;
      logic        e_stall;
      logic        e_pc;
      logic [31:0] e_tgt;
   } vec_t;
   logic clk = 1'b0;
   logic reset, d_valid, op_a_rdy, op_b_rdy, pipe_flush;
   logic [5:0] d_type;
   logic [31:0] op_a, op_b, d_target;
   logic stall_d, pc_sel, null_f, stall4, pc4, null4;
   logic [31:0] br_target, tgt4;
   logic [15:0] cnt_total, cnt_taken, cnt_null;
   logic [3:0] ct4, ck4, cn4;
   int n_chk = 0, n_pass = 0;
   bit slot_null = 1'b0;
   int m_total = 0, m_taken = 0, m_null = 0;
   vec_t tab[13];
   vec_t idle;
   always #5 clk = ~clk;
   branch_ctrl dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_type(d_type), .op_a(op_a), .op_b(op_b),
      .op_a_rdy(op_a_rdy), .op_b_rdy(op_b_rdy), .d_target(d_target), .pipe_flush(pipe_flush),
      .stall_d(stall_d), .pc_sel(pc_sel), .br_target(br_target), .null_f(null_f),
      .cnt_total(cnt_total), .cnt_taken(cnt_taken), .cnt_null(cnt_null)
   );
   branch_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_type(d_type), .op_a(op_a), .op_b(op_b),
      .op_a_rdy(op_a_rdy), .op_b_rdy(op_b_rdy), .d_target(d_target), .pipe_flush(pipe_flush),
      .stall_d(stall4), .pc_sel(pc4), .br_target(tgt4), .null_f(null4),
      .cnt_total(ct4), .cnt_taken(ck4), .cnt_null(cn4)
   );
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", n, act, exp);
   endtask
   task automatic drive(input vec_t v);
      reset = 1'b0; pipe_flush = 1'b0;
      d_valid = v.v; d_type = v.t; op_a = v.a; op_b = v.b;
      op_a_rdy = v.ar; op_b_rdy = v.br; d_target = v.tgt;
   endtask
   task automatic tick(input bit use_tab, input vec_t v);
      bit is_br, live, consider, ready, tk;
      @(negedge clk);
      is_br    = d_valid && (d_type == BEQ || d_type == BNE || d_type == BGTZL);
      live     = !reset && !pipe_flush;
      consider = live && !slot_null && is_br;
      ready    = (d_type == BGTZL) ? op_a_rdy : (op_a_rdy && op_b_rdy);
      tk       = (d_type == BEQ) ? (op_a == op_b) : (d_type == BNE) ? (op_a != op_b) : (int'(op_a) > 0);
      chk("stall_d", 32'(stall_d), 32'(consider && !ready));
      chk("pc_sel", 32'(pc_sel), 32'(consider && ready && tk));
      chk("br_target", br_target, (consider && ready && tk) ? d_target : 32'h0);
      chk("null_f", 32'(null_f), 32'(live && slot_null));
      chk("cnt_total", 32'(cnt_total), m_total % 65536);
      chk("cnt_taken", 32'(cnt_taken), m_taken % 65536);
      chk("cnt_null", 32'(cnt_null), m_null % 65536);
      chk("cnt_total_w4", 32'(ct4), m_total % 16);
      chk("cnt_taken_w4", 32'(ck4), m_taken % 16);
      chk("cnt_null_w4", 32'(cn4), m_null % 16);
      if (use_tab) begin
         chk("tab_stall", 32'(stall_d), 32'(v.e_stall));
         chk("tab_pc", 32'(pc_sel), 32'(v.e_pc));
         chk("tab_tgt", br_target, v.e_tgt);
      end
      @(posedge clk);
      if (reset) begin
         m_total = 0; m_taken = 0; m_null = 0; slot_null = 1'b0;
      end else begin
         if (consider && ready) begin
            m_total++;
            if (tk) m_taken++;
            if (d_type == BGTZL && !tk) m_null++;
         end
         slot_null = consider && ready && d_type == BGTZL && !tk;
      end
      #1;
   endtask
   initial begin
      vec_t r;
      int pick;
      idle = '{1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
      tab[0]  = '{1'b1, BEQ,   32'h5,        32'h5, 1'b1, 1'b1, 32'h3010, 1'b0, 1'b1, 32'h3010};
      tab[1]  = '{1'b1, BEQ,   32'h5,        32'h6, 1'b1, 1'b1, 32'h3010, 1'b0, 1'b0, 32'h0};
      tab[2]  = '{1'b1, BNE,   32'h1,        32'h2, 1'b1, 1'b1, 32'h4000, 1'b0, 1'b1, 32'h4000};
      tab[3]  = '{1'b1, BNE,   32'h7,        32'h7, 1'b1, 1'b1, 32'h4000, 1'b0, 1'b0, 32'h0};
      tab[4]  = '{1'b1, BGTZL, 32'hFFFFFFFF, 32'h9, 1'b1, 1'b0, 32'h5000, 1'b0, 1'b0, 32'h0};
      tab[5]  = '{1'b1, BGTZL, 32'h1,        32'h9, 1'b1, 1'b0, 32'h5000, 1'b0, 1'b1, 32'h5000};
      tab[6]  = '{1'b1, BGTZL, 32'h0,        32'h9, 1'b1, 1'b0, 32'h5000, 1'b0, 1'b0, 32'h0};
      tab[7]  = '{1'b1, BGTZL, 32'h80000000, 32'h9, 1'b1, 1'b0, 32'h5000, 1'b0, 1'b0, 32'h0};
      tab[8]  = '{1'b1, BEQ,   32'h5,        32'h5, 1'b0, 1'b1, 32'h6000, 1'b1, 1'b0, 32'h0};
      tab[9]  = '{1'b1, BNE,   32'h1,        32'h2, 1'b1, 1'b0, 32'h6000, 1'b1, 1'b0, 32'h0};
      tab[10] = '{1'b1, 6'h00, 32'h5,        32'h5, 1'b1, 1'b1, 32'h7000, 1'b0, 1'b0, 32'h0};
      tab[11] = '{1'b0, BEQ,   32'h5,        32'h5, 1'b1, 1'b1, 32'h7000, 1'b0, 1'b0, 32'h0};
      tab[12] = '{1'b1, BGTZL, 32'h3,        32'h0, 1'b0, 1'b1, 32'h7000, 1'b1, 1'b0, 32'h0};
      drive(idle); reset = 1'b1;
      tick(0, idle); tick(0, idle);
      for (int i = 0; i < 13; i++) begin
         drive(tab[i]); tick(1, tab[i]);
         drive(idle); tick(0, idle);
      end
      // operands arrive late: three stall cycles then same-cycle resolution
      drive('{1'b1, BNE, 32'h1, 32'h2, 1'b0, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0});
      repeat (3) tick(0, idle);
      op_a_rdy = 1'b1; tick(0, idle);
      drive(tab[0]); tick(0, idle);
      drive(idle); tick(0, idle);
      // not-taken BGTZL: the following branch is the nullified slot
      drive(tab[4]); tick(0, idle);
      drive(tab[0]); tick(0, idle);
      drive(idle); tick(0, idle);
      drive(tab[5]); tick(0, idle);
      drive(idle); tick(0, idle);
      // flush while waiting
      drive(tab[9]); tick(0, idle);
      pipe_flush = 1'b1; tick(0, idle);
      drive(idle); tick(0, idle);
      // reset while a nullify is pending, then 17 resolutions on the narrow counters
      drive(tab[6]); tick(0, idle);
      drive(idle); reset = 1'b1; tick(0, idle);
      reset = 1'b0; tick(0, idle);
      drive(tab[0]);
      repeat (17) tick(0, idle);
      drive(idle); tick(0, idle);
      chk("wrap_w4_total", 32'(ct4), 32'd1);
      chk("total_17", 32'(cnt_total), 32'd17);
      for (int i = 0; i < 600; i++) begin
         pick = $urandom_range(0, 3);
         r.v = $urandom_range(0, 3) != 0;
         r.t = pick == 0 ? BEQ : pick == 1 ? BNE : pick == 2 ? BGTZL : 6'($urandom);
         pick = $urandom_range(0, 5);
         r.a = pick == 0 ? 32'h0 : pick == 1 ? 32'h1 : pick == 2 ? 32'hFFFFFFFF :
               pick == 3 ? 32'h80000000 : pick == 4 ? 32'h7FFFFFFF : $urandom_range(0, 3);
         r.b = $urandom_range(0, 3);
         r.ar = $urandom_range(0, 3) != 0;
         r.br = $urandom_range(0, 3) != 0;
         r.tgt = $urandom;
         drive(r);
         pipe_flush = $urandom_range(0, 9) == 0;
         reset = $urandom_range(0, 49) == 0;
         tick(0, idle);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
